// File: rtl/otn_arq_pkg.sv
// ============================================================================
// Module  : otn_arq_pkg
// Brief   : State encoding and serial-ack symbol values for the OTN TX ARQ
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package otn_arq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_ACK_DATA = 3'd3;
    localparam logic [2:0] ST_ACK_STOP = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_SEND     = ST_SEND,
        S_WAIT_ACK = ST_WAIT_ACK,
        S_ACK_DATA = ST_ACK_DATA,
        S_ACK_STOP = ST_ACK_STOP
    } arq_state_t;

    localparam logic ACK_IDLE     = 1'b1;
    localparam logic ACK_START    = 1'b0;
    localparam logic ACK_STOP_BIT = 1'b0;
    localparam logic ACK_GOOD     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchronizer with parameterised reset value
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/tx_arq_ctrl.sv
// ============================================================================
// Module  : tx_arq_ctrl
// Brief   : Transmit-side ARQ controller: launches, retransmits and releases
//           buffered frames based on a 3-bit serial acknowledgement
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_arq_ctrl
    import otn_arq_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_arq_en,
    input  logic       i_frame_ready,
    output logic       o_send_start,
    input  logic       i_send_done,
    input  logic       i_otn_rx_ack,
    output logic       o_arq_en,
    output logic       o_arq_en_valid,
    output logic       o_frame_release,
    output logic       o_frame_drop,
    output logic [3:0] o_retry_count,
    output logic       o_busy
);

    localparam int             TW        = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0]  TMR_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [3:0]     RETRY_MAX = 4'(MAX_RETRY);

    arq_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    retry_q, retry_d;
    logic          arq_en_q, arq_en_d;
    logic          data_q, data_d;
    logic          send_start_q, send_start_d;
    logic          arq_en_valid_q, arq_en_valid_d;
    logic          release_q, release_d;
    logic          drop_q, drop_d;
    logic          busy_q, busy_d;
    logic          ack_s;
    logic          nack;

    sync_2ff #(
        .RST_VAL (ACK_IDLE)
    ) u_ack_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_otn_rx_ack),
        .o_q   (ack_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            timer_q        <= '0;
            retry_q        <= '0;
            arq_en_q       <= 1'b0;
            data_q         <= 1'b0;
            send_start_q   <= 1'b0;
            arq_en_valid_q <= 1'b0;
            release_q      <= 1'b0;
            drop_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            retry_q        <= retry_d;
            arq_en_q       <= arq_en_d;
            data_q         <= data_d;
            send_start_q   <= send_start_d;
            arq_en_valid_q <= arq_en_valid_d;
            release_q      <= release_d;
            drop_q         <= drop_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        arq_en_d       = arq_en_q;
        data_d         = data_q;
        send_start_d   = 1'b0;
        arq_en_valid_d = 1'b0;
        release_d      = 1'b0;
        drop_d         = 1'b0;
        nack           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_frame_ready) begin
                    arq_en_d       = i_arq_en;
                    retry_d        = '0;
                    send_start_d   = 1'b1;
                    arq_en_valid_d = 1'b1;
                    state_d        = S_SEND;
                end
            end
            S_SEND: begin
                if (i_send_done) begin
                    if (!arq_en_q) begin
                        release_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                // Hold at the last count so the timer cannot wrap.
                if (timer_q != TMR_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
                if (ack_s == ACK_START) begin
                    state_d = S_ACK_DATA;
                end else if (timer_q == TMR_LAST) begin
                    nack = 1'b1;
                end
            end
            S_ACK_DATA: begin
                data_d  = ack_s;
                state_d = S_ACK_STOP;
            end
            S_ACK_STOP: begin
                if ((ack_s == ACK_STOP_BIT) && (data_q == ACK_GOOD)) begin
                    release_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    nack = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (nack) begin
            if (retry_q == RETRY_MAX) begin
                release_d = 1'b1;
                drop_d    = 1'b1;
                state_d   = S_IDLE;
            end else begin
                retry_d      = retry_q + 1'b1;
                send_start_d = 1'b1;
                state_d      = S_SEND;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    assign o_send_start    = send_start_q;
    assign o_arq_en        = arq_en_q;
    assign o_arq_en_valid  = arq_en_valid_q;
    assign o_frame_release = release_q;
    assign o_frame_drop    = drop_q;
    assign o_retry_count   = retry_q;
    assign o_busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_arq_ctrl.sv
// ============================================================================
// Module  : tb_tx_arq_ctrl
// Brief   : Directed self-checking bench for tx_arq_ctrl
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tx_arq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_arq_en = 1'b0;
    logic       i_frame_ready = 1'b0;
    logic       i_send_done = 1'b0;
    logic       i_otn_rx_ack = 1'b1;
    logic       o_send_start;
    logic       o_arq_en;
    logic       o_arq_en_valid;
    logic       o_frame_release;
    logic       o_frame_drop;
    logic [3:0] o_retry_count;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int n_rel = 0;
    int n_drop = 0;
    int s0, r0, d0;

    tx_arq_ctrl #(
        .MAX_RETRY   (3),
        .ACK_TIMEOUT (16)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_arq_en        (i_arq_en),
        .i_frame_ready   (i_frame_ready),
        .o_send_start    (o_send_start),
        .i_send_done     (i_send_done),
        .i_otn_rx_ack    (i_otn_rx_ack),
        .o_arq_en        (o_arq_en),
        .o_arq_en_valid  (o_arq_en_valid),
        .o_frame_release (o_frame_release),
        .o_frame_drop    (o_frame_drop),
        .o_retry_count   (o_retry_count),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_send_start)    n_start <= n_start + 1;
        if (o_frame_release) n_rel   <= n_rel + 1;
        if (o_frame_drop)    n_drop  <= n_drop + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-ready in the current cycle; returns in the launch cycle.
    task automatic launch(input logic en);
        i_arq_en      = en;
        i_frame_ready = 1'b1;
        step();
        i_frame_ready = 1'b0;
    endtask

    // Pulses send_done now; returns in the first WAIT_ACK cycle.
    task automatic done_pulse();
        i_send_done = 1'b1;
        step();
        i_send_done = 1'b0;
    endtask

    // Drives start/data/stop on the line; returns at start-cycle + 5.
    task automatic send_ack(input logic b0, input logic b1, input logic b2);
        i_otn_rx_ack = b0;
        step();
        i_otn_rx_ack = b1;
        step();
        i_otn_rx_ack = b2;
        step();
        i_otn_rx_ack = 1'b1;
        step();
        step();
    endtask

    initial begin
        step();
        step();
        chk("rst_busy",    32'(o_busy), 0);
        chk("rst_start",   32'(o_send_start), 0);
        chk("rst_arq_en",  32'(o_arq_en), 0);
        chk("rst_retry",   32'(o_retry_count), 0);
        chk("rst_release", 32'(o_frame_release), 0);
        rst = 1'b0;
        step();

        // Non-ARQ frame
        s0 = n_start; r0 = n_rel; d0 = n_drop;
        launch(1'b0);
        chk("na_start",  32'(o_send_start), 1);
        chk("na_valid",  32'(o_arq_en_valid), 1);
        chk("na_arq_en", 32'(o_arq_en), 0);
        chk("na_busy",   32'(o_busy), 1);
        repeat (99) step();
        chk("na_no_rel_early", 32'(o_frame_release), 0);
        done_pulse();
        chk("na_release", 32'(o_frame_release), 1);
        chk("na_drop",    32'(o_frame_drop), 0);
        chk("na_busy_lo", 32'(o_busy), 0);
        step();
        chk("na_n_start", 32'(n_start - s0), 1);
        chk("na_n_rel",   32'(n_rel - r0), 1);

        // Good ack, with ignored inputs along the way
        s0 = n_start; r0 = n_rel; d0 = n_drop;
        launch(1'b1);
        chk("ga_start",  32'(o_send_start), 1);
        chk("ga_valid",  32'(o_arq_en_valid), 1);
        chk("ga_arq_en", 32'(o_arq_en), 1);
        i_arq_en      = 1'b0;
        i_frame_ready = 1'b1;
        i_otn_rx_ack  = 1'b0;
        step();
        i_frame_ready = 1'b0;
        i_otn_rx_ack  = 1'b1;
        repeat (4) step();
        chk("ig_send_no_start", 32'(o_send_start), 0);
        chk("ig_send_busy",     32'(o_busy), 1);
        chk("ig_arq_en_held",   32'(o_arq_en), 1);
        done_pulse();
        done_pulse();
        step();
        chk("ig_wait_no_start", 32'(o_send_start), 0);
        chk("ig_wait_no_rel",   32'(o_frame_release), 0);
        chk("ig_wait_busy",     32'(o_busy), 1);
        send_ack(1'b0, 1'b1, 1'b0);
        chk("ga_release", 32'(o_frame_release), 1);
        chk("ga_drop",    32'(o_frame_drop), 0);
        chk("ga_retry",   32'(o_retry_count), 0);
        chk("ga_busy_lo", 32'(o_busy), 0);
        step();
        chk("ga_n_start", 32'(n_start - s0), 1);
        chk("ga_n_rel",   32'(n_rel - r0), 1);

        // Bad ack then good
        s0 = n_start; d0 = n_drop;
        launch(1'b1);
        done_pulse();
        send_ack(1'b0, 1'b0, 1'b0);
        chk("ba_restart", 32'(o_send_start), 1);
        chk("ba_valid",   32'(o_arq_en_valid), 0);
        chk("ba_retry",   32'(o_retry_count), 1);
        chk("ba_no_rel",  32'(o_frame_release), 0);
        done_pulse();
        send_ack(1'b0, 1'b1, 1'b0);
        chk("ba_release", 32'(o_frame_release), 1);
        chk("ba_drop",    32'(o_frame_drop), 0);
        chk("ba_retry2",  32'(o_retry_count), 1);
        step();
        chk("ba_n_start", 32'(n_start - s0), 2);
        chk("ba_n_drop",  32'(n_drop - d0), 0);

        // Timeout exhaustion
        s0 = n_start; r0 = n_rel; d0 = n_drop;
        launch(1'b1);
        for (int k = 0; k < 4; k++) begin
            done_pulse();
            repeat (15) step();
            chk("to_not_early", 32'(o_send_start | o_frame_release), 0);
            step();
            if (k < 3) begin
                chk("to_restart", 32'(o_send_start), 1);
                chk("to_retry",   32'(o_retry_count), 32'(k + 1));
            end else begin
                chk("to_release", 32'(o_frame_release), 1);
                chk("to_drop",    32'(o_frame_drop), 1);
                chk("to_retry3",  32'(o_retry_count), 3);
                chk("to_busy_lo", 32'(o_busy), 0);
            end
        end
        step();
        chk("to_n_start", 32'(n_start - s0), 4);
        chk("to_n_drop",  32'(n_drop - d0), 1);
        chk("to_n_rel",   32'(n_rel - r0), 1);
        chk("to_retry_hold", 32'(o_retry_count), 3);

        // Framing error, then reset in WAIT_ACK
        launch(1'b1);
        chk("fe_retry_clr", 32'(o_retry_count), 0);
        done_pulse();
        send_ack(1'b0, 1'b1, 1'b1);
        chk("fe_restart", 32'(o_send_start), 1);
        chk("fe_retry",   32'(o_retry_count), 1);
        chk("fe_no_rel",  32'(o_frame_release), 0);
        r0 = n_rel;
        done_pulse();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_busy",   32'(o_busy), 0);
        chk("ar_arq_en", 32'(o_arq_en), 0);
        chk("ar_retry",  32'(o_retry_count), 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("ar_no_rel", 32'(n_rel - r0), 0);
        launch(1'b0);
        chk("ar_relaunch", 32'(o_send_start), 1);
        chk("ar_valid",    32'(o_arq_en_valid), 1);
        done_pulse();
        chk("ar_release",  32'(o_frame_release), 1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
